pp_pipeline_accel_wr_addr_gen: RTL and testbench

PP_PIPELINE_ACCEL_WR_ADDR_GEN -- requirements
Module: pp_pipeline_accel_wr_addr_gen

---
 rtl/pp_pipeline_accel_wr_addr_gen.sv | 166 ++++++++++++++++
 tb/tb_pp_pipeline_accel_wr_addr_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_pipeline_accel_wr_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pp_pipeline_accel_wr_addr_gen                                   |
// | Brief    : Turns (base, linestride, rows, row_bytes) into write-burst       |
// |            requests, one row at a time. Define PP_WR_ADDR_GEN_4K_SPLIT_EN   |
// |            to split bursts at 4 KB boundaries.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pp_pipeline_accel_wr_addr_gen #(
  parameter int ADDR_W   = 64,
  parameter int STRIDE_W = 32,
  parameter int CNT_W    = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_done,
  input  logic                ap_continue,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [ADDR_W-1:0]   img_out_c_dout,
  input  logic                img_out_c_empty_n,
  output logic                img_out_c_read,
  input  logic [STRIDE_W-1:0] out_img_linestride_c_dout,
  input  logic                out_img_linestride_c_empty_n,
  output logic                out_img_linestride_c_read,
  input  logic [CNT_W-1:0]    rows,
  input  logic [CNT_W-1:0]    row_bytes,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [CNT_W-1:0]    req_len,
  output logic                req_valid,
  input  logic                req_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    NEXT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]    rows_q, rows_d;
  logic [CNT_W-1:0]    row_bytes_q, row_bytes_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;

  logic                accept;
  logic [CNT_W-1:0]    chunk;
  logic [CNT_W-1:0]    row_inc;
  logic [ADDR_W-1:0]   next_row_base;

  // Both FIFOs pop together or not at all; reset masks the pop immediately.
  assign accept = ap_rst_n && (state_q == IDLE) && ap_start &&
                  img_out_c_empty_n && out_img_linestride_c_empty_n;

`ifdef PP_WR_ADDR_GEN_4K_SPLIT_EN
  logic [12:0] to_boundary;
  assign to_boundary = 13'h1000 - {1'b0, addr_q[11:0]};

  always_comb begin
    chunk = remaining_q;
    if (32'(remaining_q) > 32'(to_boundary)) begin
      chunk = CNT_W'(to_boundary);
    end
  end
`else
  assign chunk = remaining_q;
`endif

  assign row_inc       = row_q + CNT_W'(1);
  assign next_row_base = row_base_q + ADDR_W'(stride_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_base_d  = row_base_q;
    stride_d    = stride_q;
    rows_d      = rows_q;
    row_bytes_d = row_bytes_q;
    row_d       = row_q;
    remaining_d = remaining_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          stride_d    = out_img_linestride_c_dout;
          rows_d      = rows;
          row_bytes_d = row_bytes;
          row_d       = '0;
          addr_d      = img_out_c_dout;
          row_base_d  = img_out_c_dout;
          if ((rows == '0) || (row_bytes == '0)) begin
            remaining_d = '0;
            state_d     = DONE;
          end else begin
            remaining_d = row_bytes;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_ready) begin
          remaining_d = remaining_q - chunk;
          addr_d      = addr_q + ADDR_W'(chunk);
          if (remaining_q == chunk) begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        row_d = row_inc;
        if (row_inc == rows_q) begin
          state_d = DONE;
        end else begin
          row_base_d  = next_row_base;
          addr_d      = next_row_base;
          remaining_d = row_bytes_q;
          state_d     = ISSUE;
        end
      end
      DONE: begin
        if (ap_continue) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      row_base_q  <= '0;
      stride_q    <= '0;
      rows_q      <= '0;
      row_bytes_q <= '0;
      row_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_base_q  <= row_base_d;
      stride_q    <= stride_d;
      rows_q      <= rows_d;
      row_bytes_q <= row_bytes_d;
      row_q       <= row_d;
      remaining_q <= remaining_d;
    end
  end

  assign ap_done                   = (state_q == DONE);
  assign ap_idle                   = (state_q == IDLE) && !ap_start;
  assign ap_ready                  = accept;
  assign img_out_c_read            = accept;
  assign out_img_linestride_c_read = accept;
  assign req_valid                 = (state_q == ISSUE);
  assign req_addr                  = addr_q;
  assign req_len                   = chunk;

endmodule
`default_nettype wire

// File: tb/tb_pp_pipeline_accel_wr_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pp_pipeline_accel_wr_addr_gen                                |
// | Brief    : Directed self-checking bench for the write address generator.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pp_pipeline_accel_wr_addr_gen;

  localparam int ADDR_W   = 64;
  localparam int STRIDE_W = 32;
  localparam int CNT_W    = 16;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic                ap_start = 1'b0;
  logic                ap_continue = 1'b0;
  logic                ap_done, ap_idle, ap_ready;
  logic [ADDR_W-1:0]   base_dout = '0;
  logic                base_empty_n = 1'b0;
  logic                base_read;
  logic [STRIDE_W-1:0] stride_dout = '0;
  logic                stride_empty_n = 1'b0;
  logic                stride_read;
  logic [CNT_W-1:0]    rows_i = '0;
  logic [CNT_W-1:0]    row_bytes_i = '0;
  logic [ADDR_W-1:0]   req_addr;
  logic [CNT_W-1:0]    req_len;
  logic                req_valid;
  logic                req_ready = 1'b0;

  pp_pipeline_accel_wr_addr_gen #(
    .ADDR_W  (ADDR_W),
    .STRIDE_W(STRIDE_W),
    .CNT_W   (CNT_W)
  ) u_dut (
    .ap_clk                      (ap_clk),
    .ap_rst_n                    (ap_rst_n),
    .ap_start                    (ap_start),
    .ap_done                     (ap_done),
    .ap_continue                 (ap_continue),
    .ap_idle                     (ap_idle),
    .ap_ready                    (ap_ready),
    .img_out_c_dout              (base_dout),
    .img_out_c_empty_n           (base_empty_n),
    .img_out_c_read              (base_read),
    .out_img_linestride_c_dout   (stride_dout),
    .out_img_linestride_c_empty_n(stride_empty_n),
    .out_img_linestride_c_read   (stride_read),
    .rows                        (rows_i),
    .row_bytes                   (row_bytes_i),
    .req_addr                    (req_addr),
    .req_len                     (req_len),
    .req_valid                   (req_valid),
    .req_ready                   (req_ready)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observed / expected request streams: one entry per req_valid cycle.
  logic [63:0] o_addr[$], e_addr[$];
  logic [63:0] o_len[$],  e_len[$];
  int          o_cyc[$],  e_cyc[$];
  bit          o_hs[$],   e_hs[$];
  int          o_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_req(input logic [63:0] a, input logic [63:0] l, input int c, input bit hs);
    e_addr.push_back(a);
    e_len.push_back(l);
    e_cyc.push_back(c);
    e_hs.push_back(hs);
  endtask

  task automatic compare_job(input string name, input int exp_done);
    check($sformatf("%s n_valid", name), 64'(o_addr.size()), 64'(e_addr.size()));
    for (int i = 0; i < e_addr.size() && i < o_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), o_addr[i], e_addr[i]);
      check($sformatf("%s len[%0d]", name, i), o_len[i], e_len[i]);
      check($sformatf("%s cyc[%0d]", name, i), 64'(o_cyc[i]), 64'(e_cyc[i]));
      check($sformatf("%s hs[%0d]", name, i), 64'(o_hs[i]), 64'(e_hs[i]));
    end
    check($sformatf("%s done_cyc", name), 64'(o_done), 64'(exp_done));
    e_addr.delete(); e_len.delete(); e_cyc.delete(); e_hs.delete();
  endtask

  // Cycle 0 is the pop cycle; cycle n is n clocks later.
  task automatic run_job(input logic [63:0] base, input logic [31:0] stride,
                         input logic [15:0] nrows, input logic [15:0] rb,
                         input int stride_delay, input int ready_from, input bit keep_start);
    o_addr.delete(); o_len.delete(); o_cyc.delete(); o_hs.delete();
    o_done = -1;
    @(negedge ap_clk);
    base_dout      = base;
    stride_dout    = stride;
    rows_i         = nrows;
    row_bytes_i    = rb;
    ap_start       = 1'b1;
    base_empty_n   = 1'b1;
    stride_empty_n = (stride_delay == 0);
    req_ready      = 1'b0;
    for (int k = 0; k < stride_delay; k++) begin
      #1;
      check("hold base_read", 64'(base_read), 64'd0);
      check("hold stride_read", 64'(stride_read), 64'd0);
      check("hold ap_ready", 64'(ap_ready), 64'd0);
      @(negedge ap_clk);
      if (k == stride_delay - 1) stride_empty_n = 1'b1;
    end
    #1;
    check("pop base_read", 64'(base_read), 64'd1);
    check("pop stride_read", 64'(stride_read), 64'd1);
    check("pop ap_ready", 64'(ap_ready), 64'd1);
    for (int cyc = 1; cyc <= 60 && o_done < 0; cyc++) begin
      @(negedge ap_clk);
      if (!keep_start) begin
        ap_start = 1'b0; base_empty_n = 1'b0; stride_empty_n = 1'b0;
      end
      req_ready = (cyc >= ready_from);
      #1;
      if (keep_start)
        check("busy no pop", {61'd0, base_read, stride_read, ap_ready}, 64'd0);
      if (ap_done) o_done = cyc;
      else if (req_valid) begin
        o_addr.push_back(req_addr);
        o_len.push_back(64'(req_len));
        o_cyc.push_back(cyc);
        o_hs.push_back(req_ready);
      end
    end
    if (o_done < 0) check("done timeout", 64'd0, 64'd1);
    ap_start = 1'b0; base_empty_n = 1'b0; stride_empty_n = 1'b0;
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    #1;
    check("post idle", 64'(ap_idle), 64'd1);
    check("post done", 64'(ap_done), 64'd0);
  endtask

  initial begin
    // Reset with start and both FIFOs offered: nothing may pop.
    ap_start = 1'b1; base_empty_n = 1'b1; stride_empty_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    #1;
    check("rst done", 64'(ap_done), 64'd0);
    check("rst ready", 64'(ap_ready), 64'd0);
    check("rst valid", 64'(req_valid), 64'd0);
    check("rst reads", {62'd0, base_read, stride_read}, 64'd0);
    check("rst addr", req_addr, 64'd0);
    check("rst len", 64'(req_len), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1; ap_start = 1'b0; base_empty_n = 1'b0; stride_empty_n = 1'b0;
    #1;
    check("idle after rst", 64'(ap_idle), 64'd1);

    // Three rows, one request each, one bubble per row change.
    run_job(64'h1000, 32'h800, 16'd3, 16'h400, 0, 1, 1'b0);
    exp_req(64'h1000, 64'h400, 1, 1'b1);
    exp_req(64'h1800, 64'h400, 3, 1'b1);
    exp_req(64'h2000, 64'h400, 5, 1'b1);
    compare_job("basic", 7);

    // Row straddling a 4 KB boundary.
    run_job(64'hF00, 32'h2000, 16'd1, 16'h300, 0, 1, 1'b0);
`ifdef PP_WR_ADDR_GEN_4K_SPLIT_EN
    exp_req(64'hF00, 64'h100, 1, 1'b1);
    exp_req(64'h1000, 64'h200, 2, 1'b1);
    compare_job("split4k", 4);
`else
    exp_req(64'hF00, 64'h300, 1, 1'b1);
    compare_job("split4k", 3);
`endif

    // Empty jobs: pop and ready happen, no request, done immediately.
    run_job(64'h3000, 32'h100, 16'd0, 16'h100, 0, 1, 1'b0);
    compare_job("rows0", 1);
    run_job(64'h3000, 32'h100, 16'd2, 16'h0, 0, 1, 1'b0);
    compare_job("bytes0", 1);

    // Backpressure for 5 cycles; start kept high to prove no re-accept while busy.
    run_job(64'h4000, 32'h100, 16'd2, 16'h80, 0, 6, 1'b1);
    for (int c = 1; c <= 5; c++) exp_req(64'h4000, 64'h80, c, 1'b0);
    exp_req(64'h4000, 64'h80, 6, 1'b1);
    exp_req(64'h4100, 64'h80, 8, 1'b1);
    compare_job("stall", 10);

    // Stride FIFO empty for 3 cycles.
    run_job(64'h8000, 32'h40, 16'd2, 16'h20, 3, 1, 1'b0);
    exp_req(64'h8000, 64'h20, 1, 1'b1);
    exp_req(64'h8040, 64'h20, 3, 1'b1);
    compare_job("stride_wait", 5);

    // Reset during the second of four rows.
    @(negedge ap_clk);
    base_dout = 64'h10000; stride_dout = 32'h1000; rows_i = 16'd4; row_bytes_i = 16'h100;
    ap_start = 1'b1; base_empty_n = 1'b1; stride_empty_n = 1'b1; req_ready = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0; base_empty_n = 1'b0; stride_empty_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    #1;
    check("row2 valid", 64'(req_valid), 64'd1);
    check("row2 addr", req_addr, 64'h11000);
    ap_rst_n = 1'b0; ap_start = 1'b1; base_empty_n = 1'b1; stride_empty_n = 1'b1;
    #1;
    check("in rst no pop", {62'd0, base_read, stride_read}, 64'd0);
    @(negedge ap_clk);
    #1;
    check("midrst valid", 64'(req_valid), 64'd0);
    check("midrst addr", req_addr, 64'd0);
    check("midrst len", 64'(req_len), 64'd0);
    check("midrst ready", 64'(ap_ready), 64'd0);
    check("midrst done", 64'(ap_done), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1; ap_start = 1'b0; base_empty_n = 1'b0; stride_empty_n = 1'b0;
    #1;
    check("midrst idle", 64'(ap_idle), 64'd1);

    // New job after reset; second row address wraps to zero.
    run_job(64'hFFFF_FFFF_FFFF_F800, 32'h800, 16'd2, 16'h400, 0, 1, 1'b0);
    exp_req(64'hFFFF_FFFF_FFFF_F800, 64'h400, 1, 1'b1);
    exp_req(64'h0, 64'h400, 3, 1'b1);
    compare_job("wrap", 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
